// File: rtl/pdp11_io_pkg.sv
// Shared PDP-11 I/O definitions for the DCJ11 side: device addresses,
// PPS bit positions, bus GP codes and the punch-channel handshake states.
package pdp11_io_pkg;

   localparam logic [21:0] PPS_ADDR = 22'o17777554;
   localparam logic [21:0] PPB_ADDR = 22'o17777556;

   localparam int PPS_ERR_BIT   = 15;
   localparam int PPS_READY_BIT = 7;
   localparam int PPS_IE_BIT    = 6;

   localparam logic [7:0] GP_INIT = 8'o014;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESENT  = 2'd1,
      WAIT_REL = 2'd2
   } punch_state_t;

endpackage

// File: rtl/pc11_punch_chan_if.sv
// Apple II side of the PC11 punch channel: four-phase stb/ack byte handshake.
interface pc11_punch_chan_if;
   logic       a2_stb;
   logic [7:0] a2_data;
   logic       a2_ack;

   modport master (output a2_stb, output a2_data, input a2_ack);
   modport slave  (input a2_stb, input a2_data, output a2_ack);
endinterface

// File: rtl/pc11_punch_chan_byte_fifo.sv
// DEPTH x 8 byte FIFO with head/tail pointers, occupancy count and sync clear.
// Full is judged before any same-cycle pop, so a push at full is always dropped.
module byte_fifo #(
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          push,
   input  logic [7:0]    din,
   input  logic          pop,
   output logic [7:0]    dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[head];

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push && !clr) mem[tail] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (clr) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) tail <= tail + 1'b1;
         if (do_pop)  head <= head + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/pc11_punch_chan.sv
// PC11 paper-tape punch channel: PPB bytes from the DCJ11 are queued and handed
// to the Apple II over stb/ack; PPS status is live. Optional IRQ: PC11_PUNCH_IRQ_EN.
module pc11_punch_chan
   import pdp11_io_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     bus_init,
   input  logic                     ppb_wr,
   input  logic [7:0]               ppb_wdata,
   input  logic                     pps_wr,
   input  logic [15:0]              pps_wdata,
   output logic [15:0]              pps_rdata,
   pc11_punch_chan_if.master        a2,
   output logic [CW-1:0]            fifo_count,
   output logic                     irq_req
);
   punch_state_t state;
   logic         stb;
   logic [7:0]   data;
   logic         err;
   logic         ie;
   logic         pop;
   logic         full;
   logic         empty;
   logic [7:0]   head;

   assign pop = (state == PRESENT) && a2.a2_ack && !bus_init;

   byte_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus_init),
      .push  (ppb_wr),
      .din   (ppb_wdata),
      .pop   (pop),
      .dout  (head),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );

   // bus_init parks the FSM in WAIT_REL so a host mid-handshake drops ack first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         stb   <= 1'b0;
         data  <= '0;
         err   <= 1'b0;
      end else if (bus_init) begin
         state <= WAIT_REL;
         stb   <= 1'b0;
         data  <= '0;
         err   <= 1'b0;
      end else begin
         if (ppb_wr && full) err <= 1'b1;
         case (state)
            IDLE: if (!empty && !a2.a2_ack) begin
               data  <= head;
               stb   <= 1'b1;
               state <= PRESENT;
            end
            PRESENT: if (a2.a2_ack) begin
               stb   <= 1'b0;
               state <= WAIT_REL;
            end
            WAIT_REL: if (!a2.a2_ack) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign a2.a2_stb  = stb;
   assign a2.a2_data = data;

`ifdef PC11_PUNCH_IRQ_EN
   logic [14:0] unused_pps_bits;
   assign unused_pps_bits = {pps_wdata[15:7], pps_wdata[5:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ie      <= 1'b0;
         irq_req <= 1'b0;
      end else if (bus_init) begin
         ie      <= 1'b0;
         irq_req <= 1'b0;
      end else begin
         if (pps_wr) ie <= pps_wdata[PPS_IE_BIT];
         irq_req <= ie & ~full;
      end
   end
`else
   logic [16:0] unused_pps_write;
   assign unused_pps_write = {pps_wr, pps_wdata};
   assign ie      = 1'b0;
   assign irq_req = 1'b0;
`endif

   always_comb begin
      pps_rdata                = '0;
      pps_rdata[PPS_ERR_BIT]   = err;
      pps_rdata[PPS_READY_BIT] = ~full;
      pps_rdata[PPS_IE_BIT]    = ie;
   end
endmodule

// File: tb/tb_pc11_punch_chan.sv
// Directed bench for pc11_punch_chan (DEPTH=16); IRQ checks follow PC11_PUNCH_IRQ_EN.
`timescale 1ns/1ps
module tb_pc11_punch_chan;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bus_init = 1'b0;
   logic        ppb_wr = 1'b0;
   logic [7:0]  ppb_wdata = '0;
   logic        pps_wr = 1'b0;
   logic [15:0] pps_wdata = '0;
   logic [15:0] pps_rdata;
   logic [4:0]  fifo_count;
   logic        irq_req;
   int          n_chk = 0;
   int          n_bad = 0;

   pc11_punch_chan_if a2_if ();

   pc11_punch_chan #(.DEPTH(16), .CW(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus_init   (bus_init),
      .ppb_wr     (ppb_wr),
      .ppb_wdata  (ppb_wdata),
      .pps_wr     (pps_wr),
      .pps_wdata  (pps_wdata),
      .pps_rdata  (pps_rdata),
      .a2         (a2_if),
      .fifo_count (fifo_count),
      .irq_req    (irq_req)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      ppb_wr = 1'b1;
      ppb_wdata = b;
      tick();
      ppb_wr = 1'b0;
   endtask

   // Host takes the presented byte: ack high 3 cycles, low 2 cycles.
   task automatic host_take(input string tag, input logic [7:0] exp);
      int guard = 0;
      while (!a2_if.a2_stb && guard < 10) begin
         tick();
         guard++;
      end
      check_eq({tag, "_stb"}, a2_if.a2_stb, 1);
      check_eq({tag, "_data"}, a2_if.a2_data, exp);
      a2_if.a2_ack = 1'b1;
      tick();
      check_eq({tag, "_stb_drop"}, a2_if.a2_stb, 0);
      tick();
      tick();
      a2_if.a2_ack = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      a2_if.a2_ack = 1'b0;
      tick();
      tick();
      check_eq("rst_stb", a2_if.a2_stb, 0);
      check_eq("rst_data", a2_if.a2_data, 0);
      check_eq("rst_count", fifo_count, 0);
      check_eq("rst_pps", pps_rdata, 16'h0080);
      check_eq("rst_irq", irq_req, 0);
      rst_n = 1'b1;
      tick();

      // 1: single byte latency
      push(8'h41);
      check_eq("t1_stb_n1", a2_if.a2_stb, 0);
      check_eq("t1_count", fifo_count, 1);
      tick();
      check_eq("t1_stb_n2", a2_if.a2_stb, 1);
      check_eq("t1_data", a2_if.a2_data, 8'h41);
      check_eq("t1_pps", pps_rdata, 16'h0080);
      a2_if.a2_ack = 1'b1;
      tick();
      check_eq("t1_stb_ack", a2_if.a2_stb, 0);
      check_eq("t1_count_pop", fifo_count, 0);
      a2_if.a2_ack = 1'b0;
      tick();
      tick();

      // 2: three bytes in order
      push(8'h41);
      push(8'h42);
      push(8'h43);
      check_eq("t2_count3", fifo_count, 3);
      host_take("t2_b0", 8'h41);
      host_take("t2_b1", 8'h42);
      host_take("t2_b2", 8'h43);
      check_eq("t2_count0", fifo_count, 0);
      check_eq("t2_stb_end", a2_if.a2_stb, 0);

      // 3: overflow
      for (int i = 0; i < 17; i++) push(8'(i));
      check_eq("t3_count", fifo_count, 16);
      check_eq("t3_pps_full", pps_rdata, 16'h8000);
      check_eq("t3_data", a2_if.a2_data, 8'h00);
      a2_if.a2_ack = 1'b1;
      tick();
      check_eq("t3_count_pop", fifo_count, 15);
      check_eq("t3_pps_pop", pps_rdata, 16'h8080);
      a2_if.a2_ack = 1'b0;
      tick();
      tick();

      // 4: bus_init mid-handshake
      check_eq("t4_stb", a2_if.a2_stb, 1);
      check_eq("t4_data", a2_if.a2_data, 8'h01);
      a2_if.a2_ack = 1'b1;
      bus_init = 1'b1;
      tick();
      bus_init = 1'b0;
      check_eq("t4_stb_init", a2_if.a2_stb, 0);
      check_eq("t4_count_init", fifo_count, 0);
      check_eq("t4_pps_init", pps_rdata, 16'h0080);
      tick();
      push(8'h77);
      tick();
      tick();
      check_eq("t4_stb_held", a2_if.a2_stb, 0);
      check_eq("t4_count_held", fifo_count, 1);
      a2_if.a2_ack = 1'b0;
      tick();
      check_eq("t4_stb_rel1", a2_if.a2_stb, 0);
      tick();
      check_eq("t4_stb_rel2", a2_if.a2_stb, 1);
      check_eq("t4_data_new", a2_if.a2_data, 8'h77);
      a2_if.a2_ack = 1'b1;
      tick();
      a2_if.a2_ack = 1'b0;
      tick();
      tick();
      check_eq("t4_count_end", fifo_count, 0);

      // 5: push at full coinciding with pop is dropped
      for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
      check_eq("t5_count", fifo_count, 16);
      check_eq("t5_data", a2_if.a2_data, 8'h80);
      a2_if.a2_ack = 1'b1;
      ppb_wr = 1'b1;
      ppb_wdata = 8'h55;
      tick();
      ppb_wr = 1'b0;
      check_eq("t5_count_after", fifo_count, 15);
      check_eq("t5_pps_err", pps_rdata, 16'h8080);
      check_eq("t5_stb", a2_if.a2_stb, 0);
      a2_if.a2_ack = 1'b0;
      tick();
      tick();
      host_take("t5_b1", 8'h81);
      host_take("t5_b2", 8'h82);
      check_eq("t5_count_drain", fifo_count, 13);
      bus_init = 1'b1;
      tick();
      bus_init = 1'b0;
      tick();
      check_eq("t5_count_clr", fifo_count, 0);
      check_eq("t5_pps_clr", pps_rdata, 16'h0080);

      // 6: interrupt enable
      pps_wr = 1'b1;
      pps_wdata = 16'h0040;
      tick();
      pps_wr = 1'b0;
      tick();
`ifdef PC11_PUNCH_IRQ_EN
      check_eq("t6_irq_on", irq_req, 1);
      check_eq("t6_pps_ie", pps_rdata, 16'h00C0);
`else
      check_eq("t6_irq_off", irq_req, 0);
      check_eq("t6_pps_noie", pps_rdata, 16'h0080);
`endif
      for (int i = 0; i < 16; i++) push(8'(8'hA0 + i));
      tick();
      check_eq("t6_irq_full", irq_req, 0);
`ifdef PC11_PUNCH_IRQ_EN
      check_eq("t6_pps_full", pps_rdata, 16'h0040);
`else
      check_eq("t6_pps_full", pps_rdata, 16'h0000);
`endif
      bus_init = 1'b1;
      tick();
      bus_init = 1'b0;
      check_eq("t6_irq_init", irq_req, 0);
      check_eq("t6_pps_init", pps_rdata, 16'h0080);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
